// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and
// the width helpers used to size its counters.
package pulse_stretcher_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_pending_counter.sv
// Saturating event counter: inc and dec together hold, dec at zero is
// ignored, and an inc that cannot be absorbed raises o_drop.
module pending_counter #(
  parameter int MAX_COUNT = 3,
  parameter int W         = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_drop
);

  logic [W-1:0] r_count;
  logic         w_dec_eff;
  logic         w_full;

  assign w_dec_eff = i_dec && (r_count != '0);
  assign w_full    = (r_count == W'(MAX_COUNT));
  assign o_drop    = i_inc && !w_dec_eff && w_full;
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && !w_dec_eff && !w_full) begin
      r_count <= r_count + W'(1);
    end else if (w_dec_eff && !i_inc) begin
      r_count <= r_count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length high windows
// separated by a guaranteed low gap, queueing events that arrive while busy.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter  int HIGH_CYCLES = 4,
  parameter  int GAP_CYCLES  = 1,
  parameter  int MAX_PENDING = 3,
  localparam int CNT_W       = width_for(max_of(HIGH_CYCLES, GAP_CYCLES)),
  localparam int PEND_W      = width_for(MAX_PENDING)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              overflow_clr,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending_count,
  output logic              overflow
);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_overflow;

  logic              w_last;
  logic              w_gap_end;
  logic              w_inc;
  logic              w_dec;
  logic              w_drop;
  logic [PEND_W-1:0] w_pend;

  assign w_last    = (r_cnt == '0);
  assign w_gap_end = (r_state == ST_GAP) && w_last;

  // A pulse on the last gap cycle with nothing queued starts the next window
  // directly; otherwise any pulse while busy goes through the queue.
  assign w_inc = pulse_in &&
                 ((r_state == ST_HIGH) ||
                  ((r_state == ST_GAP) && !(w_gap_end && (w_pend == '0))));
  assign w_dec = w_gap_end && (w_pend != '0);

  pending_counter #(
    .MAX_COUNT (MAX_PENDING),
    .W         (PEND_W)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_count (w_pend),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pulse_in) begin
            r_state <= ST_HIGH;
            r_cnt   <= CNT_W'(HIGH_CYCLES - 1);
          end
        end
        ST_HIGH: begin
          if (w_last) begin
            r_state <= ST_GAP;
            r_cnt   <= CNT_W'(GAP_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (w_last) begin
            if ((w_pend != '0) || pulse_in) begin
              r_state <= ST_HIGH;
              r_cnt   <= CNT_W'(HIGH_CYCLES - 1);
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear must leave overflow set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign level_out     = (r_state == ST_HIGH);
  assign busy          = (r_state != ST_IDLE);
  assign pending_count = w_pend;
  assign overflow      = r_overflow;

endmodule
